// File: rtl/align_job_scheduler.sv
// Job sequencer for the aligner core: turns host SET_PARAM / LOAD_T / RUN(N) commands into
// core strobes, buffers each query's score with its tag, and aborts jobs whose core never answers.
module align_job_scheduler #(
  parameter int RES_W      = 16,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD_CYC  = 3,
  parameter int TMO_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  input  logic [CNT_W-1:0] i_run_count,
  output logic             o_cmd_ready,
  output logic             o_set_t,
  output logic             o_start_cal,
  output logic             o_param_valid,
  input  logic             i_core_busy,
  input  logic             i_core_valid,
  input  logic [RES_W-1:0] i_core_result,
  output logic             o_res_valid,
  output logic [RES_W-1:0] o_res_data,
  output logic [CNT_W-1:0] o_res_tag,
  input  logic             i_res_ready,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PULSE     = 3'd1;
  localparam logic [2:0] S_GUARD     = 3'd2;
  localparam logic [2:0] S_WAIT_IDLE = 3'd3;
  localparam logic [2:0] S_WAIT_RES  = 3'd4;

  localparam logic [1:0] CMD_SET  = 2'd1;
  localparam logic [1:0] CMD_LOAD = 2'd2;
  localparam logic [1:0] CMD_RUN  = 2'd3;

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GCNT_W = $clog2(GUARD_CYC + 1);
  localparam int ENT_W  = CNT_W + RES_W;

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  tag_q, tag_d;
  logic [GCNT_W-1:0] guard_q, guard_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              got_q, got_d;
  logic              err_q, err_d;
  logic              set_t_q, set_t_d;
  logic              start_cal_q, start_cal_d;
  logic              param_valid_q, param_valid_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [CNT_W-1:0]  res_tag_q, res_tag_d;

  logic push, pop, enter_guard, tmo_tick;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    n_d           = n_q;
    tag_d         = tag_q;
    guard_d       = guard_q;
    tmo_d         = tmo_q;
    got_d         = got_q;
    err_d         = err_q;
    set_t_d       = 1'b0;
    start_cal_d   = 1'b0;
    param_valid_d = 1'b0;
    push          = 1'b0;
    pop           = res_valid_q & i_res_ready;
    enter_guard   = 1'b0;
    tmo_tick      = 1'b0;
    mem_d         = mem_q;
    wr_d          = wr_q;
    rd_d          = rd_q;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd)
            CMD_SET: begin
              op_d    = CMD_SET;
              err_d   = 1'b0;
              state_d = S_PULSE;
            end
            CMD_LOAD: begin
              op_d    = CMD_LOAD;
              state_d = S_PULSE;
            end
            CMD_RUN: begin
              if (i_run_count != '0) begin
                op_d    = CMD_RUN;
                n_d     = i_run_count;
                tag_d   = '0;
                state_d = S_PULSE;
              end
            end
            default: ;
          endcase
        end
      end
      S_PULSE: begin
        case (op_q)
          CMD_SET: begin
            param_valid_d = 1'b1;
            enter_guard   = 1'b1;
          end
          CMD_LOAD: begin
            set_t_d     = 1'b1;
            enter_guard = 1'b1;
          end
          CMD_RUN: begin
            // Only launch a query when its result is guaranteed a FIFO slot.
            if (fcnt_q < FCNT_W'(FIFO_DEPTH)) begin
              start_cal_d = 1'b1;
              enter_guard = 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_GUARD: begin
        guard_d = guard_q + GCNT_W'(1);
        if (op_q == CMD_RUN && i_core_valid && !got_q) begin
          push  = 1'b1;
          tag_d = tag_q + CNT_W'(1);
          got_d = 1'b1;
        end
        if (guard_q == GCNT_W'(GUARD_CYC - 1)) begin
          if (op_q != CMD_RUN)   state_d = S_WAIT_IDLE;
          else if (!got_d)       state_d = S_WAIT_RES;
          else if (tag_d == n_q) state_d = S_WAIT_IDLE;
          else                   state_d = S_PULSE;
        end
      end
      S_WAIT_IDLE: begin
        if (!i_core_busy) state_d = S_IDLE;
        else              tmo_tick = 1'b1;
      end
      S_WAIT_RES: begin
        if (i_core_valid) begin
          push    = 1'b1;
          tag_d   = tag_q + CNT_W'(1);
          state_d = (tag_d == n_q) ? S_WAIT_IDLE : S_PULSE;
        end else begin
          tmo_tick = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_guard) begin
      state_d = S_GUARD;
      guard_d = '0;
      tmo_d   = '0;
      got_d   = 1'b0;
    end

    // A hung job abandons its remaining queries; already buffered results stay readable.
    if (tmo_tick) begin
      tmo_d = tmo_q + TMO_W'(1);
      if (tmo_d == {TMO_W{1'b1}}) begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    end

    if (push) begin
      mem_d[wr_q] = {tag_q, i_core_result};
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    fcnt_d      = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);
    res_valid_d = (fcnt_d != '0);
    {res_tag_d, res_data_d} = res_valid_d ? mem_d[rd_d] : '0;
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      n_q           <= '0;
      tag_q         <= '0;
      guard_q       <= '0;
      tmo_q         <= '0;
      got_q         <= 1'b0;
      err_q         <= 1'b0;
      set_t_q       <= 1'b0;
      start_cal_q   <= 1'b0;
      param_valid_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      wr_q          <= '0;
      rd_q          <= '0;
      fcnt_q        <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_tag_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      n_q           <= n_d;
      tag_q         <= tag_d;
      guard_q       <= guard_d;
      tmo_q         <= tmo_d;
      got_q         <= got_d;
      err_q         <= err_d;
      set_t_q       <= set_t_d;
      start_cal_q   <= start_cal_d;
      param_valid_q <= param_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      fcnt_q        <= fcnt_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_tag_q     <= res_tag_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_busy        = ~cmd_ready_q;
  assign o_err         = err_q;
  assign o_set_t       = set_t_q;
  assign o_start_cal   = start_cal_q;
  assign o_param_valid = param_valid_q;
  assign o_res_valid   = res_valid_q;
  assign o_res_data    = res_data_q;
  assign o_res_tag     = res_tag_q;

endmodule
